// File: rtl/qlal4s3b_cell_macro.sv
// Fabric cell macro stand-in: two integer clock dividers with glitch-free run
// enables, each paired with a reset that releases after RST_CYC divided-clock rises.

module qlal4s3b_clk_div #(
  parameter int unsigned DIV     = 2,
  parameter int unsigned RST_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic clk_out,
  output logic rst_out
);

  localparam int unsigned HI = DIV / 2;
  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned CW = $clog2(RST_CYC + 1);

  logic [PW-1:0] phase;
  logic          active;
  logic [CW-1:0] rel_cnt;

  logic [PW-1:0] phase_inc_c;
  logic          last_c;
  logic          start_c;
  logic          run_c;
  logic          out_c;

  // A new period may only begin from idle or at the end of the current one,
  // so dropping en never truncates a high or low pulse.
  always_comb begin
    phase_inc_c = phase + PW'(1);
    last_c      = (phase == PW'(DIV - 1));
    start_c     = en && (!active || last_c);
    run_c       = active && !last_c;
    out_c       = start_c || (run_c && (phase_inc_c < PW'(HI)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      active  <= 1'b0;
      clk_out <= 1'b0;
      rel_cnt <= '0;
      rst_out <= 1'b1;
    end else begin
      active  <= start_c || run_c;
      phase   <= run_c ? phase_inc_c : '0;
      clk_out <= out_c;
      // Reset release counts 0->1 transitions of the divided clock, saturating.
      if (out_c && !clk_out) begin
        if (rel_cnt != CW'(RST_CYC)) rel_cnt <= rel_cnt + CW'(1);
        if (rel_cnt == CW'(RST_CYC - 1)) rst_out <= 1'b0;
      end
    end
  end

endmodule

module qlal4s3b_cell_macro #(
  parameter int unsigned DIV0    = 2,
  parameter int unsigned DIV1    = 24,
  parameter int unsigned RST_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic Sys_Clk0_En,
  input  logic Sys_Clk1_En,
  output logic Sys_Clk0,
  output logic Sys_Clk0_Rst,
  output logic Sys_Clk1,
  output logic Sys_Clk1_Rst
);

  generate
    if (DIV0 < 2 || DIV1 < 2 || RST_CYC < 1) begin : g_bad_params
      $error("qlal4s3b_cell_macro: DIV0/DIV1 must be >= 2 and RST_CYC >= 1");
    end
  endgenerate

  qlal4s3b_clk_div #(.DIV(DIV0), .RST_CYC(RST_CYC)) u_div0 (
    .clk     (clk),
    .rst     (rst),
    .en      (Sys_Clk0_En),
    .clk_out (Sys_Clk0),
    .rst_out (Sys_Clk0_Rst)
  );

  qlal4s3b_clk_div #(.DIV(DIV1), .RST_CYC(RST_CYC)) u_div1 (
    .clk     (clk),
    .rst     (rst),
    .en      (Sys_Clk1_En),
    .clk_out (Sys_Clk1),
    .rst_out (Sys_Clk1_Rst)
  );

endmodule

// File: tb/tb_qlal4s3b_cell_macro.sv
// Bench for qlal4s3b_cell_macro: default instance plus a DIV0=5/DIV1=3/RST_CYC=2
// instance, checked every cycle against a period-counting model and directed literals.

module tb_qlal4s3b_cell_macro;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en0a = 1'b1, en1a = 1'b1, en0b = 1'b1, en1b = 1'b1;
  logic clk0a, rst0a, clk1a, rst1a;
  logic clk0b, rst0b, clk1b, rst1b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qlal4s3b_cell_macro u_dut_a (
    .clk(clk), .rst(rst), .Sys_Clk0_En(en0a), .Sys_Clk1_En(en1a),
    .Sys_Clk0(clk0a), .Sys_Clk0_Rst(rst0a), .Sys_Clk1(clk1a), .Sys_Clk1_Rst(rst1a)
  );

  qlal4s3b_cell_macro #(.DIV0(5), .DIV1(3), .RST_CYC(2)) u_dut_b (
    .clk(clk), .rst(rst), .Sys_Clk0_En(en0b), .Sys_Clk1_En(en1b),
    .Sys_Clk0(clk0b), .Sys_Clk0_Rst(rst0b), .Sys_Clk1(clk1b), .Sys_Clk1_Rst(rst1b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: k = cycles into the current period, -1 when idle; output is high for
  // the first DIV/2 cycles of a period; reset drops on the RST_CYC-th rise.
  int divs[4] = '{2, 24, 5, 3};
  int rcs[4]  = '{4, 4, 2, 2};
  int m_k[4]     = '{-1, -1, -1, -1};
  int m_rises[4] = '{0, 0, 0, 0};
  logic m_out[4] = '{0, 0, 0, 0};
  logic m_rst[4] = '{1, 1, 1, 1};

  function automatic logic en_of(input int d);
    case (d)
      0: return en0a;
      1: return en1a;
      2: return en0b;
      default: return en1b;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        m_k[d] = -1; m_rises[d] = 0; m_out[d] = 1'b0; m_rst[d] = 1'b1;
      end else begin
        logic nout;
        if (m_k[d] < 0) begin
          if (en_of(d)) m_k[d] = 0;
        end else begin
          m_k[d] = m_k[d] + 1;
          if (m_k[d] == divs[d]) m_k[d] = en_of(d) ? 0 : -1;
        end
        nout = (m_k[d] >= 0) && (m_k[d] < divs[d] / 2);
        if (nout && !m_out[d]) m_rises[d] = m_rises[d] + 1;
        m_out[d] = nout;
        m_rst[d] = (m_rises[d] < rcs[d]);
      end
    end
  end

  // Every-cycle comparison of all eight outputs against the model.
  always @(negedge clk) begin
    chk("clk0a", int'(clk0a), int'(m_out[0])); chk("rst0a", int'(rst0a), int'(m_rst[0]));
    chk("clk1a", int'(clk1a), int'(m_out[1])); chk("rst1a", int'(rst1a), int'(m_rst[1]));
    chk("clk0b", int'(clk0b), int'(m_out[2])); chk("rst0b", int'(rst0b), int'(m_rst[2]));
    chk("clk1b", int'(clk1b), int'(m_out[3])); chk("rst1b", int'(rst1b), int'(m_rst[3]));
  end

  task automatic edge_sample();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [9:0] pat_b;
    logic [3:0] pat_a;
    logic prev;
    int highs, rises, highs2;

    #1 rst = 1'b1;
    repeat (3) edge_sample();
    chk("reset_clk0a", int'(clk0a), 0);
    chk("reset_rst0a", int'(rst0a), 1);
    chk("reset_rst1a", int'(rst1a), 1);
    rst = 1'b0;

    // Scenarios 1-3: free running after release.
    pat_a = '0; pat_b = '0; highs = 0; rises = 0; prev = 1'b0;
    for (int i = 1; i <= 240; i++) begin
      edge_sample();
      if (i <= 4) pat_a = {pat_a[2:0], clk0a};
      if (i <= 10) pat_b = {pat_b[8:0], clk0b};
      if (clk1a) highs++;
      if (clk1a && !prev) rises++;
      prev = clk1a;
      if (i == 6) chk("s1_rst0a_edge6", int'(rst0a), 1);
      if (i == 7) chk("s1_rst0a_edge7", int'(rst0a), 0);
      if (i == 72) chk("s2_rst1a_edge72", int'(rst1a), 1);
      if (i == 73) chk("s2_rst1a_edge73", int'(rst1a), 0);
      if (i == 3) chk("b_rst1b_edge3", int'(rst1b), 1);
      if (i == 4) chk("b_rst1b_edge4", int'(rst1b), 0);
    end
    chk("s1_clk0a_pattern", int'(pat_a), 'b1010);
    chk("s3_clk0b_pattern", int'(pat_b), 'b1100011000);
    chk("s2_clk1a_highs", highs, 120);
    chk("s2_clk1a_rises", rises, 10);

    // Scenario 4: drop En1 at phase 3, period completes, then re-enable.
    highs = 0; highs2 = 0;
    for (int i = 241; i <= 306; i++) begin
      edge_sample();
      if (i <= 280 && clk1a) highs++;
      if (i >= 281 && i <= 304 && clk1a) highs2++;
      if (i == 244) en1a = 1'b0;
      if (i == 264) chk("s4_clk1a_low_end", int'(clk1a), 0);
      if (i == 280) begin
        chk("s4_clk1a_held", int'(clk1a), 0);
        en1a = 1'b1;
      end
      if (i == 281) chk("s4_clk1a_restart", int'(clk1a), 1);
    end
    chk("s4_highs_disabled_window", highs, 12);
    chk("s4_highs_after_restart", highs2, 12);

    // Scenario 5: asynchronous reset in the middle of a Sys_Clk1 high phase.
    chk("s5_clk1a_high_before", int'(clk1a), 1);
    rst = 1'b1;
    #1;
    chk("s5_async_clk1a", int'(clk1a), 0);
    chk("s5_async_clk0a", int'(clk0a), 0);
    chk("s5_async_rst0a", int'(rst0a), 1);
    chk("s5_async_rst1a", int'(rst1a), 1);
    chk("s5_async_rst1b", int'(rst1b), 1);
    repeat (2) edge_sample();
    rst = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      edge_sample();
      if (i == 1) chk("s5_clk0a_first", int'(clk0a), 1);
      if (i == 6) chk("s5_rst0a_edge6", int'(rst0a), 1);
      if (i == 7) chk("s5_rst0a_edge7", int'(rst0a), 0);
      if (i == 73) chk("s5_rst1a_edge73", int'(rst1a), 0);
    end

    // Scenario 6: En0 held low from reset onward.
    rst = 1'b1;
    en0a = 1'b0;
    repeat (2) edge_sample();
    rst = 1'b0;
    highs = 0;
    for (int i = 1; i <= 100; i++) begin
      edge_sample();
      if (clk0a) highs++;
      if (i == 72) chk("s6_rst1a_edge72", int'(rst1a), 1);
      if (i == 73) chk("s6_rst1a_edge73", int'(rst1a), 0);
    end
    chk("s6_clk0a_highs", highs, 0);
    chk("s6_rst0a_held", int'(rst0a), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qlal4s3b_cell_macro.md
Name: qlal4s3b_cell_macro

Overview:
- Clock/reset generator standing in for the SoC fabric cell macro.
- Derives two fabric clocks, Sys_Clk0 and Sys_Clk1, from the single oscillator clock by integer division.
- Provides a reset output for each derived clock that asserts immediately and releases in step with that clock.
- User logic (e.g. the clock/LCD core) takes Sys_Clk0 as its only clock; with default parameters and a 24 MHz clk, Sys_Clk0 is 12 MHz.

Parameters:
- DIV0, 2: clk cycles per Sys_Clk0 period; must be >= 2.
- DIV1, 24: clk cycles per Sys_Clk1 period; must be >= 2.
- RST_CYC, 4: number of derived-clock rising events before that clock's reset deasserts; must be >= 1.

Ports:
- clk  input  1  oscillator clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- Sys_Clk0_En  input  1  run enable for Sys_Clk0.
- Sys_Clk1_En  input  1  run enable for Sys_Clk1.
- Sys_Clk0  output  1  divided clock 0, registered.
- Sys_Clk0_Rst  output  1  active-high reset for the Sys_Clk0 domain.
- Sys_Clk1  output  1  divided clock 1, registered.
- Sys_Clk1_Rst  output  1  active-high reset for the Sys_Clk1 domain.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). Every register is in the clk domain.
- While rst=1:
  - phase counters = 0;
  - Sys_Clk0 = Sys_Clk1 = 0;
  - Sys_Clk0_Rst = Sys_Clk1_Rst = 1;
  - reset-release counters = 0.
- Divider n (n = 0 or 1; identical logic, parameterised by DIVn):
  - HIn = floor(DIVn/2).
  - Phase counter width is clog2(DIVn).
  - Phase counter counts 0..DIVn-1 and wraps to 0.
  - Output is registered: Sys_Clkn = 1 for the HIn clk cycles starting when the phase is 0, and 0 for the remaining DIVn-HIn cycles.
  - For odd DIVn the low phase is one cycle longer than the high phase.
  - First enabled rising clk edge after rst falls: Sys_Clkn goes 1 (phase 0).
  - Example: DIV0=2 gives a 1-high/1-low toggle. DIV1=24 gives 12 high/12 low.
- Enable handling (glitch-free):
  - Sys_Clkn_En is sampled on every clk edge.
  - If it is 0 while a period is in progress, that period completes fully; no truncated high or low pulse is allowed.
  - At the period boundary the phase holds at 0 and Sys_Clkn stays 0.
  - When En is next sampled 1, the following edge starts a new period with Sys_Clkn=1.
  - En=1 during reset has no effect until rst falls.
- Rising event: a clk edge at which Sys_Clkn changes 0->1.
- Reset release for domain n:
  - The release counter increments on each rising event of Sys_Clkn, saturating at RST_CYC.
  - Sys_Clkn_Rst goes 0 on the same clk edge on which the RST_CYC-th rising event occurs.
  - Once released, Sys_Clkn_Rst stays 0 until rst is asserted again.
  - A disabled clock produces no rising events, so its reset stays asserted.
- rst asserted mid-operation: all outputs take their reset values immediately (asynchronously), and the release sequence restarts from zero.
- The two dividers and the two reset releasers are fully independent; there is no phase relationship between Sys_Clk0 and Sys_Clk1.
- Elaboration fails if DIVn < 2 or RST_CYC < 1.

Test Plan:
1. Defaults, En0=1, rst pulsed then released -> Sys_Clk0 toggles every clk edge starting 1 on the first edge. Sys_Clk0_Rst falls on the edge of the 4th Sys_Clk0 rise (clk edge 7 after release).
2. DIV1=24, En1=1, 240 clk cycles after reset -> exactly 10 full Sys_Clk1 periods, each 12 high / 12 low. Sys_Clk1_Rst falls at clk edge 73 (the 4th rise).
3. DIV0=5 -> Sys_Clk0 pattern is 2 high / 3 low, repeating; period 5.
4. En1 dropped to 0 at phase 3 of a DIV1=24 period -> high phase and low phase both complete, then Sys_Clk1 is held 0. En1 re-raised -> Sys_Clk1=1 on the next edge, with a full period and no runt pulse.
5. rst asserted asynchronously mid-high-phase -> Sys_Clk0/1 go 0 and both _Rst outputs go 1 without waiting for a clk edge. After release the count restarts and the release sequence repeats as in scenario 1.
6. En0=0 from reset onward -> Sys_Clk0 stays 0 and Sys_Clk0_Rst stays 1 indefinitely, while domain 1 operates normally.
